// File: rtl/img_ds_pkg.sv
// Shared types and defaults for the image down-sampling datapath.
package img_ds_pkg;

  localparam int PIX_W_DEF     = 8;
  localparam int LOG2_NPIX_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DIV  = 2'd2,
    WB   = 2'd3
  } avg_state_t;

endpackage

// File: rtl/avg_div_round.sv
// Combinational divide-by-2**LOG2_NPIX with optional round-half-up and
// saturation back down to PIX_W bits.
module avg_div_round #(
  parameter int PIX_W     = 8,
  parameter int LOG2_NPIX = 2,
  parameter int ROUND     = 1
) (
  input  logic [PIX_W+LOG2_NPIX-1:0] acc,
  output logic [PIX_W-1:0]           avg
);

  localparam int ACC_W = PIX_W + LOG2_NPIX;
  localparam logic [ACC_W:0] RND =
    (ROUND != 0) ? (ACC_W+1)'((1 << LOG2_NPIX) >> 1) : '0;

  logic [ACC_W:0] biased;
  logic [ACC_W:0] shifted;

  always_comb begin
    biased  = {1'b0, acc} + RND;
    shifted = biased >> LOG2_NPIX;
    // Only the rounding carry can push the quotient past PIX_W bits.
    if (|shifted[ACC_W:PIX_W]) avg = '1;
    else                       avg = shifted[PIX_W-1:0];
  end

endmodule

// File: rtl/pixel_avg_unit.sv
// Accumulates NPIX pixels, writes their rounded average onto bus3 and
// strobes wr/enY for one cycle so the destination register captures it.
module pixel_avg_unit
  import img_ds_pkg::*;
#(
  parameter int PIX_W     = PIX_W_DEF,
  parameter int LOG2_NPIX = LOG2_NPIX_DEF,
  parameter int ROUND     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 pix_vld,
  output logic [PIX_W-1:0]     bus3,
  output logic                 wr,
  output logic                 enY,
  output logic                 busy,
  output logic                 done,
  output logic [LOG2_NPIX:0]   pix_cnt
);

  localparam int ACC_W = PIX_W + LOG2_NPIX;
  localparam logic [LOG2_NPIX:0] CNT_ONE  = (LOG2_NPIX+1)'(1);
  localparam logic [LOG2_NPIX:0] CNT_LAST = (LOG2_NPIX+1)'((1 << LOG2_NPIX) - 1);

  avg_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [PIX_W-1:0] avg;

  avg_div_round #(
    .PIX_W     (PIX_W),
    .LOG2_NPIX (LOG2_NPIX),
    .ROUND     (ROUND)
  ) u_div (
    .acc (acc),
    .avg (avg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      bus3    <= '0;
      pix_cnt <= '0;
      wr      <= 1'b0;
      enY     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr   <= 1'b0;
      enY  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            pix_cnt <= '0;
            busy    <= 1'b1;
            state   <= ACC;
          end
        end
        ACC: begin
          if (abort) begin
            acc     <= '0;
            pix_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (pix_vld) begin
            acc     <= acc + ACC_W'(pix_in);
            pix_cnt <= pix_cnt + CNT_ONE;
            if (pix_cnt == CNT_LAST) state <= DIV;
          end
        end
        DIV: begin
          if (abort) begin
            acc     <= '0;
            pix_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            bus3  <= avg;
            wr    <= 1'b1;
            enY   <= 1'b1;
            state <= WB;
          end
        end
        WB: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_avg_unit.sv
// Directed bench for pixel_avg_unit: a rounding and a truncating instance
// share stimulus; expected averages are queued when the last pixel is driven.
module tb_pixel_avg_unit;

  logic       clk = 1'b0;
  logic       rst, start, abort, pix_vld;
  logic [7:0] pix_in;
  logic [7:0] bus3, bus3_t;
  logic       wr, enY, busy, done;
  logic       wr_t, enY_t, busy_t, done_t;
  logic [2:0] pix_cnt, pix_cnt_t;

  int vectors = 0;
  int miscompares = 0;
  int q_rnd[$];
  int q_trn[$];
  int last_rnd = 0;
  int last_trn = 0;

  always #5 clk = ~clk;

  pixel_avg_unit #(.PIX_W(8), .LOG2_NPIX(2), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_in(pix_in), .pix_vld(pix_vld),
    .bus3(bus3), .wr(wr), .enY(enY), .busy(busy), .done(done),
    .pix_cnt(pix_cnt)
  );

  pixel_avg_unit #(.PIX_W(8), .LOG2_NPIX(2), .ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_in(pix_in), .pix_vld(pix_vld),
    .bus3(bus3_t), .wr(wr_t), .enY(enY_t), .busy(busy_t), .done(done_t),
    .pix_cnt(pix_cnt_t)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_block(input int a, input int b, input int c, input int d,
                           input int gap_at, input bit poke_start, input bit with_abort);
    int px[4];
    int sum;
    int er, et;
    px = '{a, b, c, d};
    sum = a + b + c + d;
    start = 1'b1;
    abort = with_abort;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("blk_busy", busy, 1);
    chk("blk_cnt0", pix_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 2; g++) begin
          pix_vld = 1'b0;
          pix_in  = 8'hEE;
          start   = poke_start;
          step();
          start = 1'b0;
          chk("stall_cnt", pix_cnt, i);
          chk("stall_busy", busy, 1);
          chk("stall_wr", wr, 0);
        end
      end
      pix_in  = px[i][7:0];
      pix_vld = 1'b1;
      if (i == 3) begin
        er = (sum + 2) >> 2;
        if (er > 255) er = 255;
        et = sum >> 2;
        q_rnd.push_back(er);
        q_trn.push_back(et);
      end
      step();
      pix_vld = 1'b0;
      chk("acc_cnt", pix_cnt, i + 1);
    end
    chk("div_wr", wr, 0);
    step();
    chk("wb_wr", wr, 1);
    chk("wb_enY", enY, 1);
    chk("wb_done", done, 0);
    last_rnd = q_rnd.pop_front();
    last_trn = q_trn.pop_front();
    chk("wb_bus3_rnd", bus3, last_rnd);
    chk("wb_bus3_trn", bus3_t, last_trn);
    chk("wb_wr_trn", wr_t, 1);
    step();
    chk("post_wr", wr, 0);
    chk("post_enY", enY, 0);
    chk("post_done", done, 1);
    chk("post_busy", busy, 0);
    chk("post_cnt", pix_cnt, 4);
    chk("hold_bus3", bus3, last_rnd);
    step();
    chk("done_pulse", done, 0);
    chk("hold_bus3_2", bus3, last_rnd);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_vld = 1'b0; pix_in = 8'h00;
    step();
    step();
    chk("rst_bus3", bus3, 0);
    chk("rst_wr", wr, 0);
    chk("rst_enY", enY, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", pix_cnt, 0);
    chk("rst_bus3_trn", bus3_t, 0);
    rst = 1'b0;
    step();

    run_block(10, 20, 30, 40, -1, 1'b0, 1'b0);
    run_block(1, 2, 2, 2, -1, 1'b0, 1'b0);
    run_block(255, 255, 255, 255, -1, 1'b0, 1'b0);
    run_block(0, 0, 0, 0, -1, 1'b0, 1'b0);
    run_block(8, 8, 8, 8, 2, 1'b1, 1'b0);
    run_block(200, 201, 202, 203, -1, 1'b0, 1'b1);

    // abort after two pixels
    start = 1'b1; step(); start = 1'b0;
    pix_vld = 1'b1; pix_in = 8'd5; step();
    pix_in = 8'd7; step();
    abort = 1'b1; pix_in = 8'd9; step();
    abort = 1'b0; pix_vld = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cnt", pix_cnt, 0);
    chk("abort_bus3", bus3, last_rnd);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_wr", wr, 0);
      chk("abort_no_done", done, 0);
    end
    run_block(3, 4, 5, 6, -1, 1'b0, 1'b0);

    // abort coinciding with the final pixel
    start = 1'b1; step(); start = 1'b0;
    pix_vld = 1'b1; pix_in = 8'd50;
    step(); step(); step();
    abort = 1'b1; step();
    abort = 1'b0; pix_vld = 1'b0;
    chk("abort_last_busy", busy, 0);
    chk("abort_last_cnt", pix_cnt, 0);
    step();
    chk("abort_last_wr", wr, 0);
    chk("abort_last_bus3", bus3, last_rnd);

    // abort in DIV
    start = 1'b1; step(); start = 1'b0;
    pix_vld = 1'b1; pix_in = 8'd90;
    for (int i = 0; i < 4; i++) step();
    pix_vld = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_div_wr", wr, 0);
    chk("abort_div_busy", busy, 0);
    chk("abort_div_bus3", bus3, last_rnd);
    step();
    chk("abort_div_done", done, 0);

    // rst in DIV
    start = 1'b1; step(); start = 1'b0;
    pix_vld = 1'b1; pix_in = 8'd100;
    for (int i = 0; i < 4; i++) step();
    pix_vld = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("rdiv_wr", wr, 0);
    chk("rdiv_bus3", bus3, 0);
    chk("rdiv_busy", busy, 0);
    chk("rdiv_done", done, 0);
    chk("rdiv_cnt", pix_cnt, 0);
    step();
    chk("rdiv_wr2", wr, 0);
    chk("rdiv_busy2", busy, 0);

    run_block(60, 61, 62, 63, -1, 1'b0, 1'b0);

    // rst in WB
    start = 1'b1; step(); start = 1'b0;
    pix_vld = 1'b1; pix_in = 8'd200;
    for (int i = 0; i < 4; i++) step();
    pix_vld = 1'b0;
    step();
    chk("rwb_pre_wr", wr, 1);
    chk("rwb_pre_bus3", bus3, 200);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rwb_wr", wr, 0);
    chk("rwb_enY", enY, 0);
    chk("rwb_bus3", bus3, 0);
    step();
    chk("rwb_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
